// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// Module : pipe_pkg
// Brief  : Shared pipeline types and constants for the fetch/decode stages.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
    localparam int          PIPE_PC_WIDTH = 32;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic                     valid;
        logic [31:0]              instr;
        logic [PIPE_PC_WIDTH-1:0] pc_plus1;
    } ifid_t;

endpackage

`default_nettype wire

// File: rtl/ifid_reg.sv
//------------------------------------------------------------------------------
// Module : ifid_reg
// Brief  : Pipeline register with hold / bubble / load controls.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ifid_reg #(
    parameter int               WIDTH  = 65,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hold,
    input  logic             i_bubble,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Bubble beats hold so a flush during a stall still squashes the slot.
    always_ff @(posedge clk) begin
        if (rst || i_bubble) begin
            r_q <= BUBBLE;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/fetch_pc_stage.sv
//------------------------------------------------------------------------------
// Module : fetch_pc_stage
// Brief  : PC register, next-PC/halt FSM and IF/ID capture. Optional
//          performance counters under FETCH_PERF_CNT_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_pc_stage #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  IMEM_DEPTH = 2000,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [31:0]         NOP_WORD   = pipe_pkg::NOP_WORD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] pc,
    input  logic [31:0]         instr_in,
    output logic                ifid_valid,
    output logic [31:0]         ifid_instr,
    output logic [PC_WIDTH-1:0] ifid_pc_plus1,
    output logic                halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    import pipe_pkg::*;

    localparam int                  c_IFID_W = 1 + 32 + PC_WIDTH;
    localparam logic [PC_WIDTH-1:0] c_DEPTH  = PC_WIDTH'(IMEM_DEPTH);
    localparam logic [PC_WIDTH-1:0] c_LAST   = PC_WIDTH'(IMEM_DEPTH - 1);
    localparam logic [PC_WIDTH-1:0] c_ONE    = PC_WIDTH'(1);
    localparam logic [c_IFID_W-1:0] c_BUBBLE = {1'b0, NOP_WORD, {PC_WIDTH{1'b0}}};

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_nxt;
    logic [PC_WIDTH-1:0]   w_pc_plus1;
    logic                  w_hold;
    logic                  w_bubble;
    logic                  w_redirect_ok;
    logic [c_IFID_W-1:0]   w_ifid_d;
    logic [c_IFID_W-1:0]   w_ifid_q;

    assign w_pc_plus1    = r_pc + c_ONE;
    assign w_redirect_ok = (redirect_pc < c_DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold      = 1'b0;
        w_bubble    = 1'b0;
        case (r_state)
            RUN: begin
                if (redirect_valid) begin
                    w_bubble = 1'b1;
                    if (w_redirect_ok) begin
                        w_pc_nxt = redirect_pc;
                    end else begin
                        w_pc_nxt    = c_LAST;
                        w_state_nxt = HALT;
                    end
                end else if (stall) begin
                    w_hold   = 1'b1;
                    w_bubble = flush;
                end else begin
                    w_bubble = flush;
                    // Last word is still captured; PC parks there instead of wrapping.
                    if (w_pc_plus1 < c_DEPTH) begin
                        w_pc_nxt = w_pc_plus1;
                    end else begin
                        w_state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                w_bubble = 1'b1;
                if (redirect_valid && w_redirect_ok) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign w_ifid_d = {1'b1, instr_in, w_pc_plus1};

    ifid_reg #(
        .WIDTH  (c_IFID_W),
        .BUBBLE (c_BUBBLE)
    ) u_ifid_reg (
        .clk      (clk),
        .rst      (reset),
        .i_hold   (w_hold),
        .i_bubble (w_bubble),
        .i_d      (w_ifid_d),
        .o_q      (w_ifid_q)
    );

    assign pc            = r_pc;
    assign ifid_valid    = w_ifid_q[c_IFID_W-1];
    assign ifid_instr    = w_ifid_q[PC_WIDTH +: 32];
    assign ifid_pc_plus1 = w_ifid_q[PC_WIDTH-1:0];
    assign halted        = (r_state == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_fetch_evt;
    logic        w_stall_evt;

    assign w_fetch_evt = (r_state == RUN) && !redirect_valid && !stall && !flush;
    assign w_stall_evt = (r_state == RUN) && !redirect_valid && stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_fetch_evt && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_stage.sv
//------------------------------------------------------------------------------
// Module : tb_fetch_pc_stage
// Brief  : Self-checking bench for fetch_pc_stage with a behavioural model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_pc_stage;

    localparam int DEPTH = 2000;

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] instr_in;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus1;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    logic [31:0] k [0:DEPTH-1];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pp1, m_fcnt, m_scnt;
    logic        m_v, m_halt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign instr_in = (pc < DEPTH) ? k[pc] : 32'hDEAD_BEEF;

    fetch_pc_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .instr_in       (instr_in),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    wire [97:0] act_vec = {pc, ifid_valid, ifid_instr, ifid_pc_plus1, halted};

    function automatic logic [97:0] exp_vec();
        return {m_pc, m_v, m_instr, m_pp1, m_halt};
    endfunction

    task automatic bubble_m();
        m_v = 1'b0; m_instr = 32'h0; m_pp1 = 32'h0;
    endtask

    // Applies one cycle of inputs to DUT and model, then waits past the edge.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic rv, input logic [31:0] rpc);
        reset = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
        if (r) begin
            m_pc = 0; m_halt = 0; bubble_m(); m_fcnt = 0; m_scnt = 0;
        end else if (m_halt) begin
            bubble_m();
            if (rv && rpc < DEPTH) begin m_pc = rpc; m_halt = 0; end
        end else if (rv) begin
            bubble_m();
            if (rpc >= DEPTH) begin m_halt = 1; m_pc = DEPTH - 1; end
            else m_pc = rpc;
        end else if (s) begin
            if (m_scnt != 32'hFFFF_FFFF) m_scnt++;
            if (f) bubble_m();
        end else begin
            if (f) bubble_m();
            else begin
                m_v = 1; m_instr = k[m_pc]; m_pp1 = m_pc + 1;
                if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
            end
            if (m_pc + 1 < DEPTH) m_pc = m_pc + 1;
            else m_halt = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        vectors++;
        if (act_vec !== {32'd0, 1'b0, 32'd0, 32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got %h want pc=0 v=0 instr=0 pp1=0 halt=0", act_vec);
        end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 0);
            vectors++;
            if (pc !== 32'(i) || act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL free_run[%0d]: got %h want %h", i, act_vec, exp_vec());
            end
            if (i == 1 || i == 4) begin
                vectors++;
                if (ifid_instr !== (i == 1 ? 32'h8E11_0000 : 32'h8E12_0009) ||
                    ifid_pc_plus1 !== 32'(i) || ifid_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL free_run_word[%0d]: got instr=%h pp1=%0d v=%b", i,
                             ifid_instr, ifid_pc_plus1, ifid_valid);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [97:0] held;
        step(0, 0, 0, 0, 0);
        held = act_vec;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            vectors++;
            if (pc !== 32'd5 || act_vec !== held || act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %h want %h", i, act_vec, held);
            end
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (pc !== 32'd6 || act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL stall_release: got %h want %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_redirect_stall();
        step(0, 1, 0, 1, 32'd87);
        vectors++;
        if (pc !== 32'd87 || ifid_valid !== 1'b0 || act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL redirect_stall: got %h want %h", act_vec, exp_vec());
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (ifid_instr !== k[87] || ifid_valid !== 1'b1 || act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL redirect_fetch: got %h want %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_end_of_mem();
        step(0, 0, 0, 1, 32'd1998);
        step(0, 0, 0, 0, 0);
        vectors++;
        if (pc !== 32'd1999 || halted !== 1'b0 || act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL eom_1999: got %h want %h", act_vec, exp_vec());
        end
        step(0, 0, 0, 0, 0);
        vectors++;
        if (pc !== 32'd1999 || halted !== 1'b1 || ifid_valid !== 1'b1 ||
            ifid_instr !== k[1999] || ifid_pc_plus1 !== 32'd2000) begin
            miscompares++;
            $display("FAIL eom_last: got %h want %h", act_vec, exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            step(0, i == 1, 0, 0, 0);
            vectors++;
            if (pc !== 32'd1999 || halted !== 1'b1 || ifid_valid !== 1'b0 ||
                act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL eom_halt[%0d]: got %h want %h", i, act_vec, exp_vec());
            end
        end
        step(0, 0, 0, 1, 32'd24);
        vectors++;
        if (pc !== 32'd24 || halted !== 1'b0 || act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL eom_resume: got %h want %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_redirect_oob();
        step(0, 0, 0, 1, 32'd2500);
        vectors++;
        if (halted !== 1'b1 || pc !== 32'd1999 || ifid_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL oob_run: got %h want %h", act_vec, exp_vec());
        end
        step(0, 0, 0, 1, 32'd2000);
        vectors++;
        if (halted !== 1'b1 || pc !== 32'd1999 || act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL oob_halt: got %h want %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_flush();
        step(0, 0, 0, 1, 32'd10);
        step(0, 0, 1, 0, 0);
        vectors++;
        if (pc !== 32'd11 || ifid_valid !== 1'b0 || ifid_instr !== 32'd0 ||
            act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL flush: got %h want %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid_stall();
        step(0, 0, 0, 1, 32'd40);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        vectors++;
        if (pc !== 32'd0 || ifid_valid !== 1'b0 || halted !== 1'b0 ||
            act_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_mid_stall: got %h want %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rpc = $urandom_range(0, 2199);
                1: rpc = $urandom_range(1990, 2001);
                2: rpc = $urandom;
                default: rpc = $urandom_range(0, 50);
            endcase
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, rpc);
            vectors++;
            if (act_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", i, act_vec, exp_vec());
            end
`ifdef FETCH_PERF_CNT_EN
            vectors++;
            if (perf_fetch_cnt !== m_fcnt || perf_stall_cnt !== m_scnt) begin
                miscompares++;
                $display("FAIL random_perf[%0d]: got %0d/%0d want %0d/%0d", i,
                         perf_fetch_cnt, perf_stall_cnt, m_fcnt, m_scnt);
            end
`endif
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        vectors++;
        if (perf_fetch_cnt !== 32'd10 || perf_stall_cnt !== 32'd3) begin
            miscompares++;
            $display("FAIL perf: got fetch=%0d stall=%0d want 10/3",
                     perf_fetch_cnt, perf_stall_cnt);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) k[i] = $urandom;
        k[0] = 32'h8E11_0000;
        k[3] = 32'h8E12_0009;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        m_pc = 0; m_halt = 0; m_v = 0; m_instr = 0; m_pp1 = 0; m_fcnt = 0; m_scnt = 0;
        #1;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_end_of_mem();
        test_redirect_oob();
        test_flush();
        test_reset_mid_stall();
        test_random();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
